// File: rtl/wb_queue_if.sv
// Bus between a result producer, the write-back queue and the register file.
// The queue side uses the slave modport and the producer/register-file side uses master.
interface wb_queue_if #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_rd;
  logic [XLEN-1:0] in_data;
  logic            hold;
  logic            WE;
  logic [4:0]      A3;
  logic [XLEN-1:0] WD;
  logic [4:0]      q_addr1;
  logic [4:0]      q_addr2;
  logic            hit1;
  logic            hit2;
  logic [XLEN-1:0] fwd1;
  logic [XLEN-1:0] fwd2;
  logic [CW-1:0]   count;

  modport master (
    output in_valid, in_rd, in_data, hold, q_addr1, q_addr2,
    input  in_ready, WE, A3, WD, hit1, hit2, fwd1, fwd2, count
  );

  modport slave (
    input  in_valid, in_rd, in_data, hold, q_addr1, q_addr2,
    output in_ready, WE, A3, WD, hit1, hit2, fwd1, fwd2, count
  );
endinterface

// File: rtl/wb_queue.sv
// In-order write-back queue. It drains one result per cycle into the register file.
// It also forwards the youngest pending value for two lookup addresses.
module wb_queue #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_queue_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [4:0]      rd_mem_q   [DEPTH];
  logic [4:0]      rd_mem_d   [DEPTH];
  logic [XLEN-1:0] data_mem_q [DEPTH];
  logic [XLEN-1:0] data_mem_d [DEPTH];

  logic            in_ready;
  logic            push;
  logic            pop;
  logic            hit1, hit2;
  logic [XLEN-1:0] fwd1, fwd2;

  // A result to x0 completes the handshake but is never stored.
  always_comb begin
    in_ready = (count_q < CW'(DEPTH));
    push     = bus.in_valid && in_ready && (bus.in_rd != 5'd0);
    pop      = (count_q != '0) && !bus.hold;
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    if (push) begin
      rd_mem_d[tail_q]   = bus.in_rd;
      data_mem_d[tail_q] = bus.in_data;
      tail_d             = tail_q + 1'b1;
    end
    if (pop) begin
      head_d = head_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is never reset. Occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    rd_mem_q   <= rd_mem_d;
    data_mem_q <= data_mem_d;
  end

  // Walk from oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    logic [PW-1:0] idx;
    idx  = '0;
    hit1 = 1'b0;
    hit2 = 1'b0;
    fwd1 = '0;
    fwd2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        if ((bus.q_addr1 != 5'd0) && (rd_mem_q[idx] == bus.q_addr1)) begin
          hit1 = 1'b1;
          fwd1 = data_mem_q[idx];
        end
        if ((bus.q_addr2 != 5'd0) && (rd_mem_q[idx] == bus.q_addr2)) begin
          hit2 = 1'b1;
          fwd2 = data_mem_q[idx];
        end
      end
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.WE       = pop;
  assign bus.A3       = (count_q != '0) ? rd_mem_q[head_q]   : 5'd0;
  assign bus.WD       = (count_q != '0) ? data_mem_q[head_q] : '0;
  assign bus.hit1     = hit1;
  assign bus.hit2     = hit2;
  assign bus.fwd1     = fwd1;
  assign bus.fwd2     = fwd2;
  assign bus.count    = count_q;

endmodule
